// File: rtl/button_pkg.sv
// Shared constants for the four-channel push-button debouncer.
// The defaults give a 10 ms stability window at 100 MHz.
package button_pkg;

    localparam int DEFAULT_STABLE_CYCLES = 1000000;
    localparam int DEFAULT_CNT_W         = 20;
    localparam int N_BTN                 = 4;

endpackage : button_pkg

// File: rtl/debounce_channel.sv
// One debounced button: two-flop synchroniser, stability counter, level and edge pulses.
// A new level is accepted only after it has held for STABLE_CYCLES synchronised cycles.
module debounce_channel
    import button_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             level_q,   level_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;

    // Any sample agreeing with the accepted level discards progress, so bounces restart the window.
    always_comb begin
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            level_d   = sync2_q;
            press_d   = sync2_q;
            release_d = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= btn_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule : debounce_channel

// File: rtl/button_debounce_4ch.sv
// Four independent debounce channels between the board buttons and the toggle bank.
// Every channel shares the clock and reset but has no other interaction.
module button_debounce_4ch
    import button_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_BTN-1:0] level_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_chan (
            .clk_i     (clk_i),
            .reset_ni  (reset_ni),
            .btn_i     (btn_i[i]),
            .level_o   (level_o[i]),
            .press_o   (press_o[i]),
            .release_o (release_o[i])
        );
    end

endmodule : button_debounce_4ch

// File: tb/tb_button_debounce_4ch.sv
// Directed bench for the four-channel debouncer with a 4-cycle stability window.
// Expected values are hand-derived: a stable new value shows up 5 edges after its first sampling edge.
module tb_button_debounce_4ch;

    logic       clk = 1'b0;
    logic       resetN;
    logic [3:0] btn;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] releaseP;

    int testCount = 0;
    int failCount = 0;

    button_debounce_4ch #(
        .STABLE_CYCLES (4),
        .CNT_W         (3)
    ) dut (
        .clk_i     (clk),
        .reset_ni  (resetN),
        .btn_i     (btn),
        .level_o   (level),
        .press_o   (press),
        .release_o (releaseP)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] btnVal);
        btn = btnVal;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expLevel,
                               input logic [3:0] expPress, input logic [3:0] expRelease);
        testCount++;
        assert (level === expLevel) else begin
            failCount++;
            $error("[TB] FAIL %s level: got %b expected %b", tag, level, expLevel);
        end
        testCount++;
        assert (press === expPress) else begin
            failCount++;
            $error("[TB] FAIL %s press: got %b expected %b", tag, press, expPress);
        end
        testCount++;
        assert (releaseP === expRelease) else begin
            failCount++;
            $error("[TB] FAIL %s release: got %b expected %b", tag, releaseP, expRelease);
        end
    endtask

    // Tick n edges, expecting a constant level and no pulses on each.
    task automatic quietTicks(input int n, input string tag, input logic [3:0] expLevel);
        for (int k = 0; k < n; k++) begin
            tick();
            checkOutput(tag, expLevel, 4'b0000, 4'b0000);
        end
    endtask

    initial begin
        // Scenario 1: buttons held through reset
        resetN = 1'b0;
        applyStimulus(4'b1111);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("reset_hold", 4'b0000, 4'b0000, 4'b0000);
        end
        resetN = 1'b1;
        quietTicks(5, "s1_wait", 4'b0000);
        tick();
        checkOutput("s1_press", 4'b1111, 4'b1111, 4'b0000);
        tick();
        checkOutput("s1_after", 4'b1111, 4'b0000, 4'b0000);

        // Return all buttons low to set up the single-channel cases
        applyStimulus(4'b0000);
        quietTicks(5, "all_low_wait", 4'b1111);
        tick();
        checkOutput("all_low_rel", 4'b0000, 4'b0000, 4'b1111);
        tick();
        checkOutput("all_low_after", 4'b0000, 4'b0000, 4'b0000);

        // Scenario 2: btn[0] rises and holds
        applyStimulus(4'b0001);
        quietTicks(5, "s2_wait", 4'b0000);
        tick();
        checkOutput("s2_press", 4'b0001, 4'b0001, 4'b0000);
        tick();
        checkOutput("s2_after", 4'b0001, 4'b0000, 4'b0000);

        // Scenario 3: btn[1] bounces 1,1,0 then holds 1
        applyStimulus(4'b0011);
        quietTicks(2, "s3_bounce_hi", 4'b0001);
        applyStimulus(4'b0001);
        quietTicks(1, "s3_bounce_lo", 4'b0001);
        applyStimulus(4'b0011);
        quietTicks(5, "s3_wait", 4'b0001);
        tick();
        checkOutput("s3_press", 4'b0011, 4'b0010, 4'b0000);
        tick();
        checkOutput("s3_after", 4'b0011, 4'b0000, 4'b0000);

        // Scenario 4: btn[2] high, 3-cycle low glitch, then real fall
        applyStimulus(4'b0111);
        quietTicks(5, "s4_rise_wait", 4'b0011);
        tick();
        checkOutput("s4_rise", 4'b0111, 4'b0100, 4'b0000);
        applyStimulus(4'b0011);
        quietTicks(3, "s4_glitch", 4'b0111);
        applyStimulus(4'b0111);
        quietTicks(6, "s4_glitch_after", 4'b0111);
        applyStimulus(4'b0011);
        quietTicks(5, "s4_fall_wait", 4'b0111);
        tick();
        checkOutput("s4_release", 4'b0011, 4'b0000, 4'b0100);
        tick();
        checkOutput("s4_after", 4'b0011, 4'b0000, 4'b0000);

        // Scenario 5: simultaneous multi-channel edges
        applyStimulus(4'b0000);
        quietTicks(5, "s5_clear_wait", 4'b0011);
        tick();
        checkOutput("s5_clear", 4'b0000, 4'b0000, 4'b0011);
        applyStimulus(4'b1010);
        quietTicks(5, "s5_a_wait", 4'b0000);
        tick();
        checkOutput("s5_press_a", 4'b1010, 4'b1010, 4'b0000);
        applyStimulus(4'b0101);
        quietTicks(5, "s5_b_wait", 4'b1010);
        tick();
        checkOutput("s5_swap", 4'b0101, 4'b0101, 4'b1010);
        tick();
        checkOutput("s5_after", 4'b0101, 4'b0000, 4'b0000);

        // Scenario 6: reset pulse mid-count discards progress
        applyStimulus(4'b0000);
        resetN = 1'b0;
        tick();
        checkOutput("s6_reset_a", 4'b0000, 4'b0000, 4'b0000);
        resetN = 1'b1;
        applyStimulus(4'b0001);
        quietTicks(3, "s6_count", 4'b0000);
        resetN = 1'b0;
        tick();
        checkOutput("s6_reset_b", 4'b0000, 4'b0000, 4'b0000);
        resetN = 1'b1;
        quietTicks(5, "s6_wait", 4'b0000);
        tick();
        checkOutput("s6_press", 4'b0001, 4'b0001, 4'b0000);
        tick();
        checkOutput("s6_after", 4'b0001, 4'b0000, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule : tb_button_debounce_4ch
